mpu_poll_sched: RTL and testbench
=================================

Name: mpu_poll_sched

Overview:
- Sequencer that drives the single-register-read I2C master for the MPU6050.
- Periodically issues one I2C read transaction per sensor data register, captures each byte and assembles signed 16-bit axis words.
- Publishes a coherent sample set with a one-cycle valid strobe.
- Sits between the I2C master and downstream motion/display logic; it is the only requester of the master.

Parameters:
- POLL_PERIOD, 50000: clk cycles from the start of one poll round to the start of the next.
- TIMEOUT, 200000: clk cycles allowed per transaction, from start request to byte received.
- BASE_REG, 8'h3B: first data register address (ACCEL_XOUT_H).

Ports:
- clk  in  1: system clock.
- reset  in  1: asynchronous, active-low reset.
- enable  in  1: 1 = polling active.
- i2c_start  out  1: start request to the master.
- i2c_stop  out  1: stop request to the master.
- i2c_reg_addr  out  8: register address presented to the master.
- i2c_data  in  8: received byte from the master.
- i2c_avail_data  in  1: byte-ready flag from the master; its rising edge marks a valid byte.
- i2c_avail_master  in  1: 1 = master is idle.
- accel_x / accel_y / accel_z  out  16 each: assembled words, high byte first.
- gyro_x / gyro_y / gyro_z  out  16 each: present only with MPU_GYRO_EN.
- sample_valid  out  1: one-cycle pulse when a new sample set is published.
- busy  out  1: 1 whenever state is not IDLE or WAIT_PERIOD.
- timeout_err  out  1: sticky transaction-timeout flag.

Behaviour:
- Reset (async, reset=0): state=IDLE. All outputs 0. Byte index=0. Period counter=0. Shadow registers=0.
- Master inputs come from a slower derived clock. Therefore:
  - start and stop are level-held until acknowledged via i2c_avail_master.
  - i2c_avail_data is edge-detected with one register.
- States:
  - IDLE: if enable=1, go to ISSUE with index=0 and period counter cleared.
  - ISSUE: i2c_reg_addr=BASE_REG+index; i2c_start=1. When i2c_avail_master=0, drop start and go to WAIT_BYTE.
  - WAIT_BYTE: on a rising edge of i2c_avail_data, latch i2c_data into shadow[index] in that same cycle, then go to STOP_REQ.
  - STOP_REQ: i2c_stop=1. When i2c_avail_master=1, drop stop and go to NEXT.
  - NEXT:
    - If index is the last entry, go to PUBLISH.
    - Otherwise increment index and go to ISSUE.
  - PUBLISH: copy shadow into the output words in one cycle; sample_valid=1 for exactly that cycle; clear timeout_err; go to WAIT_PERIOD.
  - WAIT_PERIOD:
    - Idle until the period counter reaches POLL_PERIOD-1, then ISSUE with index=0.
    - If enable=0, go to IDLE.
- Period counter: free-runs from the start of each round. If a round takes longer than POLL_PERIOD, the next round starts immediately after PUBLISH.
- Byte map, without MPU_GYRO_EN: index 0..5 = regs BASE_REG+0..5 → XH, XL, YH, YL, ZH, ZL. Word = {H, L}.
- Outputs change only in PUBLISH; partial rounds never appear on the outputs.
- i2c_reg_addr is stable throughout ISSUE and WAIT_BYTE.
- Timeout:
  - A per-transaction counter starts on entry to ISSUE.
  - If it reaches TIMEOUT-1 before WAIT_BYTE completes: set timeout_err, go to STOP_REQ, abort the round (no PUBLISH), return to WAIT_PERIOD.
- enable falling mid-round: the current transaction runs through STOP_REQ, then IDLE. No sample_valid is issued and outputs are held.
- Never assert i2c_start and i2c_stop in the same cycle.

Optional Feature:
- MPU_GYRO_EN defined:
  - Round extends to 14 entries.
  - Index 6 and 7 (regs 0x41/0x42, temperature) are skipped via address jump: after index 5, the next address is BASE_REG+8.
  - Bytes from BASE_REG+8..+13 fill gyro_x/y/z, high byte first.
  - All six words publish together.
- Undefined: gyro ports and related logic absent; round = 6 transactions.

Test Plan:
- Reset asserted mid-WAIT_BYTE → immediate IDLE; all outputs 0; start and stop low the same cycle.
- enable=1, master model returns 0x12,0x34,0xAB,0xCD,0x80,0x01 → addresses 0x3B..0x40 issued in order; one sample_valid; accel_x=0x1234, accel_y=0xABCD, accel_z=0x8001.
- POLL_PERIOD=1000, continuous enable → consecutive sample_valid pulses exactly 1000 cycles apart (round shorter than period).
- Master never raises avail_data on the 3rd byte, TIMEOUT=500 → timeout_err=1; stop issued; no sample_valid; outputs unchanged; next good round clears timeout_err.
- enable dropped during 2nd transaction → stop completes; state IDLE; busy=0; no sample_valid.
- MPU_GYRO_EN, model bytes 0x01..0x0C for accel then gyro → gyro_x=0x0708, gyro_z=0x0B0C; addresses 0x41/0x42 never issued.

Source files
------------

// File: rtl/mpu_poll_sched.sv
// MPU6050 poll sequencer: one I2C register read per data byte, publishes axis words.
// Define MPU_GYRO_EN to extend each round to the three gyro words.
module mpu_poll_sched #(
    parameter int unsigned POLL_PERIOD = 50000,
    parameter int unsigned TIMEOUT     = 200000,
    parameter logic [7:0]  BASE_REG    = 8'h3B
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        i2c_start,
    output logic        i2c_stop,
    output logic [7:0]  i2c_reg_addr,
    input  logic [7:0]  i2c_data,
    input  logic        i2c_avail_data,
    input  logic        i2c_avail_master,
    output logic [15:0] accel_x,
    output logic [15:0] accel_y,
    output logic [15:0] accel_z,
`ifdef MPU_GYRO_EN
    output logic [15:0] gyro_x,
    output logic [15:0] gyro_y,
    output logic [15:0] gyro_z,
`endif
    output logic        sample_valid,
    output logic        busy,
    output logic        timeout_err
);

`ifdef MPU_GYRO_EN
    localparam int         NB       = 12;
    localparam logic [3:0] LAST_IDX = 4'd13;
`else
    localparam int         NB       = 6;
    localparam logic [3:0] LAST_IDX = 4'd5;
`endif
    localparam logic [31:0] PER_LAST = 32'(POLL_PERIOD - 1);
    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BYTE,
        S_STOP_REQ,
        S_NEXT,
        S_PUBLISH,
        S_WAIT_PERIOD
    } state_t;

    state_t      state, state_n;
    logic [3:0]  idx;
    logic [3:0]  slot;
    logic [31:0] pcnt;
    logic [31:0] tcnt;
    logic        avail_q;
    logic        abort;
    logic [7:0]  shadow [NB];

    logic data_rise;
    logic to_hit;
    logic round_go;
    logic pub_go;
    logic byte_go;
    logic to_fire;

    assign data_rise = i2c_avail_data & ~avail_q;
    assign to_hit    = (tcnt == TO_LAST);

    // Temperature registers are never read, so gyro bytes pack after accel.
`ifdef MPU_GYRO_EN
    assign slot = (idx > 4'd7) ? idx - 4'd2 : idx;
`else
    assign slot = idx;
`endif

    always_comb begin
        state_n  = state;
        round_go = 1'b0;
        pub_go   = 1'b0;
        byte_go  = 1'b0;
        to_fire  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (enable) begin
                    state_n  = S_ISSUE;
                    round_go = 1'b1;
                end
            end
            S_ISSUE: begin
                if (to_hit) begin
                    state_n = S_STOP_REQ;
                    to_fire = 1'b1;
                end else if (!i2c_avail_master) begin
                    state_n = S_WAIT_BYTE;
                end
            end
            S_WAIT_BYTE: begin
                if (data_rise) begin
                    state_n = S_STOP_REQ;
                    byte_go = 1'b1;
                end else if (to_hit) begin
                    state_n = S_STOP_REQ;
                    to_fire = 1'b1;
                end
            end
            S_STOP_REQ: begin
                if (i2c_avail_master) begin
                    if (!enable) state_n = S_IDLE;
                    else if (abort) state_n = S_WAIT_PERIOD;
                    else state_n = S_NEXT;
                end
            end
            S_NEXT: begin
                if (!enable) begin
                    state_n = S_IDLE;
                end else if (idx == LAST_IDX) begin
                    state_n = S_PUBLISH;
                    pub_go  = 1'b1;
                end else begin
                    state_n = S_ISSUE;
                end
            end
            S_PUBLISH: state_n = S_WAIT_PERIOD;
            S_WAIT_PERIOD: begin
                if (!enable) begin
                    state_n = S_IDLE;
                end else if (pcnt >= PER_LAST) begin
                    state_n  = S_ISSUE;
                    round_go = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            pcnt        <= '0;
            tcnt        <= '0;
            avail_q     <= 1'b0;
            abort       <= 1'b0;
            timeout_err <= 1'b0;
            accel_x     <= '0;
            accel_y     <= '0;
            accel_z     <= '0;
`ifdef MPU_GYRO_EN
            gyro_x      <= '0;
            gyro_y      <= '0;
            gyro_z      <= '0;
`endif
            for (int i = 0; i < NB; i++) shadow[i] <= '0;
        end else begin
            state   <= state_n;
            avail_q <= i2c_avail_data;

            if (round_go) begin
                idx   <= '0;
                pcnt  <= '0;
                abort <= 1'b0;
            end else begin
                if (state != S_IDLE && pcnt < PER_LAST) pcnt <= pcnt + 32'd1;
                if (state == S_NEXT && state_n == S_ISSUE) begin
`ifdef MPU_GYRO_EN
                    idx <= (idx == 4'd5) ? 4'd8 : idx + 4'd1;
`else
                    idx <= idx + 4'd1;
`endif
                end
            end

            if (state_n == S_ISSUE && state != S_ISSUE) tcnt <= '0;
            else if (tcnt != TO_LAST) tcnt <= tcnt + 32'd1;

            if (byte_go) begin
                for (int i = 0; i < NB; i++)
                    if (slot == 4'(i)) shadow[i] <= i2c_data;
            end

            if (to_fire) begin
                abort       <= 1'b1;
                timeout_err <= 1'b1;
            end

            // Words load as PUBLISH is entered so they are valid with the strobe.
            if (pub_go) begin
                accel_x     <= {shadow[0], shadow[1]};
                accel_y     <= {shadow[2], shadow[3]};
                accel_z     <= {shadow[4], shadow[5]};
`ifdef MPU_GYRO_EN
                gyro_x      <= {shadow[6], shadow[7]};
                gyro_y      <= {shadow[8], shadow[9]};
                gyro_z      <= {shadow[10], shadow[11]};
`endif
                timeout_err <= 1'b0;
            end
        end
    end

    always_comb begin
        i2c_reg_addr = 8'd0;
        if (state == S_ISSUE || state == S_WAIT_BYTE || state == S_STOP_REQ)
            i2c_reg_addr = BASE_REG + {4'd0, idx};
    end

    assign i2c_start    = (state == S_ISSUE);
    assign i2c_stop     = (state == S_STOP_REQ);
    assign sample_valid = (state == S_PUBLISH);
    assign busy         = !(state == S_IDLE || state == S_WAIT_PERIOD);

endmodule

// File: tb/tb_mpu_poll_sched.sv
// Randomised bench for mpu_poll_sched with a behavioural I2C master model.
// Expected words come from a register-map view of the master's memory.
module tb_mpu_poll_sched;

    localparam int         P    = 1000;
    localparam int         TO   = 500;
    localparam logic [7:0] BASE = 8'h3B;
`ifdef MPU_GYRO_EN
    localparam int NB = 12;
`else
    localparam int NB = 6;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        i2c_start, i2c_stop;
    logic [7:0]  i2c_reg_addr;
    logic [7:0]  i2c_data;
    logic        i2c_avail_data, i2c_avail_master;
    logic [15:0] accel_x, accel_y, accel_z;
`ifdef MPU_GYRO_EN
    logic [15:0] gyro_x, gyro_y, gyro_z;
`endif
    logic        sample_valid, busy, timeout_err;

    mpu_poll_sched #(
        .POLL_PERIOD(P),
        .TIMEOUT    (TO),
        .BASE_REG   (BASE)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .i2c_start       (i2c_start),
        .i2c_stop        (i2c_stop),
        .i2c_reg_addr    (i2c_reg_addr),
        .i2c_data        (i2c_data),
        .i2c_avail_data  (i2c_avail_data),
        .i2c_avail_master(i2c_avail_master),
        .accel_x         (accel_x),
        .accel_y         (accel_y),
        .accel_z         (accel_z),
`ifdef MPU_GYRO_EN
        .gyro_x          (gyro_x),
        .gyro_y          (gyro_y),
        .gyro_z          (gyro_z),
`endif
        .sample_valid    (sample_valid),
        .busy            (busy),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [7:0] mem [256];
    logic [7:0] addr_q [$];
    logic [7:0] hang_addr = 8'h00;
    logic [7:0] cur = 8'h00;
    bit          jitter = 1'b0;
    int          ms = 0;
    int          dly = 0;
    int          bad_addr = 0;
    int          stop_cnt = 0;
    int unsigned cyc = 0;
    int          sv_cnt = 0;
    int unsigned sv_cyc [$];

    function automatic logic [7:0] exp_addr(input int k);
        return 8'(int'(BASE) + ((k < 6) ? k : k + 2));
    endfunction

    function automatic logic [15:0] word(input logic [7:0] a);
        return {mem[a], mem[8'(a + 8'd1)]};
    endfunction

    function automatic int pick();
        return jitter ? int'($urandom_range(0, 3)) : 1;
    endfunction

    task automatic rand_mem();
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // I2C master: acks start, returns mem[addr], releases on stop.
    initial begin
        i2c_avail_master = 1'b1;
        i2c_avail_data   = 1'b0;
        i2c_data         = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset) begin
                ms = 0;
                i2c_avail_master = 1'b1;
                i2c_avail_data   = 1'b0;
            end else begin
                case (ms)
                    0: if (i2c_start) begin
                        cur = i2c_reg_addr;
                        addr_q.push_back(cur);
                        if (cur == 8'h41 || cur == 8'h42) bad_addr++;
                        dly = pick();
                        ms = 1;
                    end
                    1: if (dly > 0) dly--;
                       else begin
                           i2c_avail_master = 1'b0;
                           dly = pick() + 2;
                           ms = 2;
                       end
                    2: if (i2c_stop) begin
                           stop_cnt++;
                           dly = pick();
                           ms = 4;
                       end else if (dly > 0) dly--;
                       else if (cur != hang_addr) begin
                           i2c_data = mem[cur];
                           i2c_avail_data = 1'b1;
                           ms = 3;
                       end
                    3: if (i2c_stop) begin
                           stop_cnt++;
                           dly = pick();
                           ms = 4;
                       end
                    4: if (dly > 0) dly--;
                       else begin
                           i2c_avail_master = 1'b1;
                           i2c_avail_data   = 1'b0;
                           ms = 0;
                       end
                    default: ms = 0;
                endcase
            end
        end
    end

    // Every published set must match the register map and the issued addresses.
    initial forever begin
        @(negedge clk);
        if (reset && sample_valid) begin
            sv_cnt++;
            sv_cyc.push_back(cyc);
            chk("accel_x", accel_x, word(BASE));
            chk("accel_y", accel_y, word(8'(BASE + 8'd2)));
            chk("accel_z", accel_z, word(8'(BASE + 8'd4)));
`ifdef MPU_GYRO_EN
            chk("gyro_x", gyro_x, word(8'(BASE + 8'd8)));
            chk("gyro_y", gyro_y, word(8'(BASE + 8'd10)));
            chk("gyro_z", gyro_z, word(8'(BASE + 8'd12)));
`endif
            chk("tmo_clear_pub", timeout_err, 1'b0);
            if (addr_q.size() >= NB) begin
                for (int k = 0; k < NB; k++)
                    chk("addr_seq", addr_q[addr_q.size() - NB + k], exp_addr(k));
            end else begin
                chk("addr_count", addr_q.size(), NB);
            end
            addr_q.delete();
        end
    end

    task automatic wait_sv(input int n, input int budget);
        for (int i = 0; i < budget && sv_cnt < n; i++) @(negedge clk);
        chk("sv_arrive", (sv_cnt >= n), 1'b1);
    endtask

    logic [15:0] hx, hy, hz;
    int          base_sv, stop0;

    initial begin
        logic [7:0] fix [6];
        fix = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h80, 8'h01};
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_ax", accel_x, 16'h0);
        chk("rst_ay", accel_y, 16'h0);
        chk("rst_az", accel_z, 16'h0);
        chk("rst_sv", sample_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_start", i2c_start, 1'b0);
        chk("rst_stop", i2c_stop, 1'b0);
        chk("rst_addr", i2c_reg_addr, 8'h00);
        chk("rst_tmo", timeout_err, 1'b0);
        reset = 1'b1;

`ifdef MPU_GYRO_EN
        for (int k = 0; k < 12; k++) mem[exp_addr(k)] = 8'(k + 1);
`else
        for (int k = 0; k < 6; k++) mem[exp_addr(k)] = fix[k];
`endif
        @(negedge clk);
        enable = 1'b1;
        wait_sv(1, 3000);
`ifdef MPU_GYRO_EN
        chk("fix_ax", accel_x, 16'h0102);
        chk("fix_gx", gyro_x, 16'h0708);
        chk("fix_gz", gyro_z, 16'h0B0C);
`else
        chk("fix_ax", accel_x, 16'h1234);
        chk("fix_ay", accel_y, 16'hABCD);
        chk("fix_az", accel_z, 16'h8001);
`endif
        chk("no_temp_addr", bad_addr, 0);

        for (int r = 0; r < 4; r++) begin
            rand_mem();
            wait_sv(sv_cnt + 1, 1500);
        end
        for (int k = 1; k < 5; k++)
            chk("period", sv_cyc[k] - sv_cyc[k-1], P);

        jitter = 1'b1;
        for (int r = 0; r < 4; r++) begin
            rand_mem();
            wait_sv(sv_cnt + 1, 1500);
        end

        hx = accel_x; hy = accel_y; hz = accel_z;
        base_sv = sv_cnt;
        stop0 = stop_cnt;
        addr_q.delete();
        hang_addr = 8'(BASE + 8'd2);
        for (int i = 0; i < 2000 && !timeout_err; i++) @(negedge clk);
        chk("tmo_set", timeout_err, 1'b1);
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        chk("tmo_idle", busy, 1'b0);
        chk("tmo_stops", stop_cnt - stop0, 3);
        chk("tmo_nosv", sv_cnt, base_sv);
        chk("tmo_hold_x", accel_x, hx);
        chk("tmo_hold_z", accel_z, hz);
        chk("tmo_naddr", addr_q.size(), 3);
        chk("tmo_sticky", timeout_err, 1'b1);
        hang_addr = 8'h00;
        addr_q.delete();
        rand_mem();
        wait_sv(sv_cnt + 1, 2000);
        chk("tmo_cleared", timeout_err, 1'b0);

        hx = accel_x; hy = accel_y; hz = accel_z;
        base_sv = sv_cnt;
        addr_q.delete();
        for (int i = 0; i < 2000 && addr_q.size() < 2; i++) @(negedge clk);
        chk("en_2nd_txn", addr_q.size(), 2);
        enable = 1'b0;
        for (int i = 0; i < 300 && busy; i++) @(negedge clk);
        repeat (P + 200) @(negedge clk);
        chk("en_busy", busy, 1'b0);
        chk("en_start", i2c_start, 1'b0);
        chk("en_stop", i2c_stop, 1'b0);
        chk("en_master_idle", i2c_avail_master, 1'b1);
        chk("en_nosv", sv_cnt, base_sv);
        chk("en_hold_y", accel_y, hy);
        chk("en_naddr", addr_q.size(), 2);

        hang_addr = 8'(BASE + 8'd1);
        enable = 1'b1;
        for (int i = 0; i < 2000 && !(ms == 2 && cur == hang_addr); i++)
            @(negedge clk);
        repeat (20) @(negedge clk);
        chk("pre_rst_busy", busy, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("arst_start", i2c_start, 1'b0);
        chk("arst_stop", i2c_stop, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_ax", accel_x, 16'h0);
        chk("arst_az", accel_z, 16'h0);
        chk("arst_addr", i2c_reg_addr, 8'h00);
        chk("arst_sv", sample_valid, 1'b0);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
